// File: rtl/fpu_defs.sv
// Shared definitions for the float-to-integer conversion path.
// Holds the default result width, the rounding-mode encoding on RM_SI and
// the operand classification carried from the unpack stage to the round stage.
package fpu_defs;

    localparam int C_INT_DEF = 32;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } cls_e;

endpackage

// File: rtl/fpu_ftoi_round.sv
// Rounding-increment decision for the float-to-integer converter.
// Ports:
//   rm     - rounding mode (RM_SI encoding, unknown codes act as RNE)
//   sign   - operand sign
//   lsb    - least significant kept bit of the truncated magnitude
//   guard  - first discarded bit
//   sticky - OR of all further discarded bits
//   inc    - 1 when the truncated magnitude must be incremented
module fpu_ftoi_round
    import fpu_defs::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fpu_ftoi_pipe.sv
// Two-stage pipelined IEEE-754 float to signed/unsigned integer converter.
// S1 unpacks, classifies and aligns the operand; S2 rounds, range-checks,
// saturates, negates and produces flags. Valid/ready handshake on both sides.
// Ports:
//   Clk_CI, Rst_RBI        - clock (rising edge), async active-low reset
//   Flush_SI               - synchronous clear of both stages
//   Valid_SI / Ready_SO    - input handshake
//   Operand_a_DI           - packed float operand, sign at MSB
//   Signed_SI, RM_SI       - result signedness and rounding mode
//   Valid_SO / Ready_SI    - output handshake
//   Result_DO              - integer result
//   OF_SO, IV_SO, IX_SO, Zero_SO - overflow, invalid, inexact, zero flags
module fpu_ftoi_pipe
    import fpu_defs::*;
#(
    parameter int C_EXP  = 8,
    parameter int C_MANT = 23,
    parameter int C_BIAS = 127,
    parameter int C_INT  = C_INT_DEF
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RBI,
    input  logic                   Flush_SI,
    input  logic                   Valid_SI,
    output logic                   Ready_SO,
    input  logic [C_EXP+C_MANT:0]  Operand_a_DI,
    input  logic                   Signed_SI,
    input  logic [2:0]             RM_SI,
    output logic                   Valid_SO,
    input  logic                   Ready_SI,
    output logic [C_INT-1:0]       Result_DO,
    output logic                   OF_SO,
    output logic                   IV_SO,
    output logic                   IX_SO,
    output logic                   Zero_SO
);

    // Aligned vector: C_INT+1 integer bits above C_MANT+1 fraction bits.
    localparam int AW = C_INT + C_MANT + 2;
    localparam int SW = $clog2(C_INT + 2);

    logic              in_sign;
    logic [C_EXP-1:0]  in_exp;
    logic [C_MANT-1:0] in_frac;
    logic              exp_zero, exp_ones, frac_zero;
    logic [C_MANT:0]   in_mant;
    cls_e              in_cls;
    int                unb_exp;
    logic [SW-1:0]     sh_amt;
    logic [AW-1:0]     aligned;
    logic [C_INT:0]    al_mag;
    logic              al_guard, al_sticky, al_ovf;

    logic              s1_valid, s1_sign, s1_guard, s1_sticky, s1_ovf, s1_signed;
    cls_e              s1_cls;
    logic [C_INT:0]    s1_mag;
    logic [2:0]        s1_rm;

    logic              s2_valid, s2_of, s2_iv, s2_ix, s2_zero;
    logic [C_INT-1:0]  s2_result;

    logic              s2_load, in_fire;

    assign s2_load  = ~s2_valid | Ready_SI;
    assign Ready_SO = ~s1_valid | ~s2_valid | Ready_SI;
    assign in_fire  = Valid_SI & Ready_SO;

    // ---------------- S1: unpack, classify, align ----------------
    assign {in_sign, in_exp, in_frac} = Operand_a_DI;
    assign exp_zero  = (in_exp == '0);
    assign exp_ones  = (in_exp == '1);
    assign frac_zero = (in_frac == '0);
    assign in_mant   = {~exp_zero, in_frac};
    // Subnormals share the smallest normal exponent with a zero hidden bit.
    assign unb_exp   = exp_zero ? (1 - C_BIAS) : (int'({1'b0, in_exp}) - C_BIAS);

    always_comb begin
        in_cls = CLS_NORM;
        if (exp_ones)
            in_cls = frac_zero ? CLS_INF : CLS_NAN;
        else if (exp_zero)
            in_cls = frac_zero ? CLS_ZERO : CLS_SUB;
    end

    // At unbiased exponent -1 the mantissa sits entirely in the fraction field,
    // so a left shift by exponent+1 places the binary point correctly.
    always_comb begin
        sh_amt    = SW'(unb_exp + 1);
        aligned   = '0;
        al_mag    = '0;
        al_guard  = 1'b0;
        al_sticky = 1'b0;
        al_ovf    = 1'b0;
        if (unb_exp > C_INT) begin
            al_ovf = 1'b1;
        end else if (unb_exp < -1) begin
            al_sticky = |in_mant;
        end else begin
            aligned   = AW'(in_mant) << sh_amt;
            al_mag    = aligned[AW-1 -: C_INT+1];
            al_guard  = aligned[C_MANT];
            al_sticky = |aligned[C_MANT-1:0];
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_cls    <= CLS_ZERO;
            s1_mag    <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_ovf    <= 1'b0;
            s1_signed <= 1'b0;
            s1_rm     <= '0;
        end else begin
            if (Flush_SI)
                s1_valid <= 1'b0;
            else if (Ready_SO)
                s1_valid <= Valid_SI;
            if (in_fire) begin
                s1_sign   <= in_sign;
                s1_cls    <= in_cls;
                s1_mag    <= al_mag;
                s1_guard  <= al_guard;
                s1_sticky <= al_sticky;
                s1_ovf    <= al_ovf;
                s1_signed <= Signed_SI;
                s1_rm     <= RM_SI;
            end
        end
    end

    // ---------------- S2: round, range check, saturate ----------------
    logic             rnd_inc;
    logic [C_INT+1:0] rnd_mag;
    logic [C_INT+1:0] lim_half;
    logic [C_INT-1:0] neg_low;
    logic [C_INT-1:0] max_s, min_s;
    logic             fits;
    logic [C_INT-1:0] nx_result;
    logic             nx_of, nx_iv;

    fpu_ftoi_round u_round (
        .rm     (s1_rm),
        .sign   (s1_sign),
        .lsb    (s1_mag[0]),
        .guard  (s1_guard),
        .sticky (s1_sticky),
        .inc    (rnd_inc)
    );

    // Rounded magnitude keeps one extra bit so a rounding carry is range-checked.
    assign rnd_mag  = {1'b0, s1_mag} + (C_INT+2)'(rnd_inc);
    assign lim_half = (C_INT+2)'(1) << (C_INT-1);
    assign neg_low  = ~rnd_mag[C_INT-1:0] + C_INT'(1);
    assign max_s    = {1'b0, {(C_INT-1){1'b1}}};
    assign min_s    = {1'b1, {(C_INT-1){1'b0}}};

    always_comb begin
        if (s1_signed)
            fits = s1_sign ? (rnd_mag <= lim_half) : (rnd_mag < lim_half);
        else
            fits = s1_sign ? (rnd_mag == '0) : (rnd_mag[C_INT+1:C_INT] == 2'b00);
    end

    always_comb begin
        nx_result = '0;
        nx_of     = 1'b0;
        nx_iv     = 1'b0;
        if (s1_cls == CLS_NAN) begin
            nx_iv     = 1'b1;
            nx_result = s1_signed ? max_s : '1;
        end else if ((s1_cls == CLS_INF) || s1_ovf || !fits) begin
            nx_of = 1'b1;
            nx_iv = 1'b1;
            if (s1_signed)
                nx_result = s1_sign ? min_s : max_s;
            else
                nx_result = s1_sign ? '0 : '1;
        end else begin
            nx_result = s1_sign ? neg_low : rnd_mag[C_INT-1:0];
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_of     <= 1'b0;
            s2_iv     <= 1'b0;
            s2_ix     <= 1'b0;
            s2_zero   <= 1'b0;
        end else begin
            if (Flush_SI)
                s2_valid <= 1'b0;
            else if (s2_load)
                s2_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                s2_result <= nx_result;
                s2_of     <= nx_of;
                s2_iv     <= nx_iv;
                s2_ix     <= (s1_guard | s1_sticky) & ~nx_iv;
                s2_zero   <= (nx_result == '0) & ~nx_iv;
            end
        end
    end

    assign Valid_SO  = s2_valid;
    assign Result_DO = s2_result;
    assign OF_SO     = s2_of;
    assign IV_SO     = s2_iv;
    assign IX_SO     = s2_ix;
    assign Zero_SO   = s2_zero;

endmodule

// File: tb/tb_fpu_ftoi_pipe.sv
module tb_fpu_ftoi_pipe;

    localparam logic [3:0] F_OF = 4'b1000;
    localparam logic [3:0] F_IV = 4'b0100;
    localparam logic [3:0] F_IX = 4'b0010;
    localparam logic [3:0] F_Z  = 4'b0001;

    logic        clk_sys = 1'b0;
    logic        rst_n, flush_si, valid_si, ready_so, signed_si;
    logic [31:0] operand;
    logic [2:0]  rm_si;
    logic        valid_so, ready_si;
    logic [31:0] result_do;
    logic        of_so, iv_so, ix_so, zero_so;
    logic [3:0]  flags;

    always #5 clk_sys = ~clk_sys;

    assign flags = {of_so, iv_so, ix_so, zero_so};

    fpu_ftoi_pipe dut (
        .Clk_CI       (clk_sys),
        .Rst_RBI      (rst_n),
        .Flush_SI     (flush_si),
        .Valid_SI     (valid_si),
        .Ready_SO     (ready_so),
        .Operand_a_DI (operand),
        .Signed_SI    (signed_si),
        .RM_SI        (rm_si),
        .Valid_SO     (valid_so),
        .Ready_SI     (ready_si),
        .Result_DO    (result_do),
        .OF_SO        (of_so),
        .IV_SO        (iv_so),
        .IX_SO        (ix_so),
        .Zero_SO      (zero_so)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    typedef struct packed {
        logic [31:0] op;
        logic        sgn;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cur_res;
    logic [3:0]  cur_flg;
    logic        saw_rdy_low;
    logic        hold_v;
    logic [31:0] hold_res;
    logic [3:0]  hold_flg;
    logic        done;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] op, input logic sgn, input logic [2:0] rm,
                                input logic [31:0] res, input logic [3:0] flg);
        vec_t v;
        v.op = op; v.sgn = sgn; v.rm = rm; v.res = res; v.flg = flg;
        return v;
    endfunction

    // Output monitor / scoreboard, sampled on the falling edge.
    initial begin
        hold_v = 1'b0;
        saw_rdy_low = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check_val("stall_valid", valid_so, 1);
                    check_val("stall_result", result_do, hold_res);
                    check_val("stall_flags", flags, hold_flg);
                end
                if (!ready_so) saw_rdy_low = 1'b1;
                if (valid_so && ready_si) begin
                    if (sb_q.size() == 0) begin
                        check_val("unexpected_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check_val("result", result_do, e.res);
                        check_val("flags", flags, e.flg);
                    end
                end
                if (flush_si)
                    sb_q.delete();
                else if (valid_si && ready_so)
                    sb_q.push_back({cur_res, cur_flg});
                hold_v   = valid_so & ~ready_si & ~flush_si;
                hold_res = result_do;
                hold_flg = flags;
            end
        end
    end

    task automatic drive(input vec_t v);
        operand   = v.op;
        signed_si = v.sgn;
        rm_si     = v.rm;
        cur_res   = v.res;
        cur_flg   = v.flg;
        valid_si  = 1'b1;
    endtask

    task automatic send(input vec_t v);
        logic acc;
        acc = 1'b0;
        drive(v);
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk_sys);
            acc = ready_so;
            @(posedge clk_sys);
            #1;
        end
        valid_si = 1'b0;
        if (!acc) check_val("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
            @(posedge clk_sys);
            #1;
        end
        check_val("drain_empty", sb_q.size(), 0);
    endtask

    task automatic latency(input vec_t v);
        drive(v);
        @(negedge clk_sys);
        check_val("lat_ready", ready_so, 1);
        @(posedge clk_sys);
        #1;
        valid_si = 1'b0;
        check_val("lat_cycle1", valid_so, 0);
        @(posedge clk_sys);
        #1;
        check_val("lat_cycle2", valid_so, 1);
        check_val("lat_result", result_do, v.res);
        drain();
    endtask

    initial begin
        // op, signed, rm, expected result, expected flags {OF,IV,IX,Z}
        vecs.push_back(mk(32'h3FC00000, 1, 3'd0, 32'd2,        F_IX));
        vecs.push_back(mk(32'h3FC00000, 1, 3'd1, 32'd1,        F_IX));
        vecs.push_back(mk(32'h3FC00000, 1, 3'd2, 32'd1,        F_IX));
        vecs.push_back(mk(32'h3FC00000, 1, 3'd3, 32'd2,        F_IX));
        vecs.push_back(mk(32'h4F000000, 1, 3'd0, 32'h7FFFFFFF, F_OF | F_IV));
        vecs.push_back(mk(32'h4F000000, 0, 3'd0, 32'h80000000, 4'b0000));
        vecs.push_back(mk(32'hCF000000, 1, 3'd0, 32'h80000000, 4'b0000));
        vecs.push_back(mk(32'h7FC00000, 1, 3'd0, 32'h7FFFFFFF, F_IV));
        vecs.push_back(mk(32'hFF800000, 0, 3'd0, 32'h00000000, F_OF | F_IV));
        vecs.push_back(mk(32'hBE800000, 0, 3'd1, 32'h00000000, F_IX | F_Z));
        vecs.push_back(mk(32'hBE800000, 0, 3'd2, 32'h00000000, F_OF | F_IV));
        vecs.push_back(mk(32'hBE800000, 0, 3'd3, 32'h00000000, F_IX | F_Z));
        vecs.push_back(mk(32'h40200000, 1, 3'd0, 32'd2,        F_IX));
        vecs.push_back(mk(32'h40200000, 1, 3'd4, 32'd3,        F_IX));
        vecs.push_back(mk(32'h40200000, 1, 3'd7, 32'd2,        F_IX));
        vecs.push_back(mk(32'h40600000, 1, 3'd7, 32'd4,        F_IX));
        vecs.push_back(mk(32'hC0200000, 1, 3'd0, 32'hFFFFFFFE, F_IX));
        vecs.push_back(mk(32'hC0200000, 1, 3'd2, 32'hFFFFFFFD, F_IX));
        vecs.push_back(mk(32'h00000000, 1, 3'd0, 32'h00000000, F_Z));
        vecs.push_back(mk(32'h80000000, 0, 3'd0, 32'h00000000, F_Z));
        vecs.push_back(mk(32'h437FC000, 0, 3'd3, 32'd256,      F_IX));
        vecs.push_back(mk(32'h437FC000, 0, 3'd1, 32'd255,      F_IX));
        vecs.push_back(mk(32'h00000001, 0, 3'd3, 32'd1,        F_IX));
        vecs.push_back(mk(32'h00000001, 1, 3'd2, 32'd0,        F_IX | F_Z));
        vecs.push_back(mk(32'h80000001, 1, 3'd2, 32'hFFFFFFFF, F_IX));
        vecs.push_back(mk(32'h3F000000, 1, 3'd0, 32'd0,        F_IX | F_Z));
        vecs.push_back(mk(32'h3F000000, 1, 3'd4, 32'd1,        F_IX));
        vecs.push_back(mk(32'h4F800000, 0, 3'd0, 32'hFFFFFFFF, F_OF | F_IV));
        vecs.push_back(mk(32'hCF000001, 1, 3'd0, 32'h80000000, F_OF | F_IV));
        vecs.push_back(mk(32'h7F800000, 1, 3'd0, 32'h7FFFFFFF, F_OF | F_IV));
        vecs.push_back(mk(32'hFFC00000, 0, 3'd0, 32'hFFFFFFFF, F_IV));
        vecs.push_back(mk(32'h4F7FFFFF, 0, 3'd0, 32'hFFFFFF00, 4'b0000));
        vecs.push_back(mk(32'h4EFFFFFF, 1, 3'd0, 32'h7FFFFF80, 4'b0000));
        vecs.push_back(mk(32'hBF400000, 0, 3'd0, 32'h00000000, F_OF | F_IV));
        vecs.push_back(mk(32'hBF400000, 0, 3'd1, 32'h00000000, F_IX | F_Z));
        vecs.push_back(mk(32'hBF800000, 1, 3'd0, 32'hFFFFFFFF, 4'b0000));
        vecs.push_back(mk(32'hBF800000, 0, 3'd0, 32'h00000000, F_OF | F_IV));
        vecs.push_back(mk(32'h3F800000, 1, 3'd0, 32'd1,        4'b0000));

        rst_n = 1'b0; flush_si = 1'b0; valid_si = 1'b0; ready_si = 1'b1;
        operand = '0; signed_si = 1'b0; rm_si = '0; cur_res = '0; cur_flg = '0;

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        check_val("rst_valid", valid_so, 0);
        check_val("rst_result", result_do, 0);
        check_val("rst_flags", flags, 0);
        rst_n = 1'b1;
        @(negedge clk_sys);
        check_val("rst_ready", ready_so, 1);
        @(posedge clk_sys);
        #1;

        // Full vector table under random backpressure
        done = 1'b0;
        fork
            begin
                foreach (vecs[i]) send(vecs[i]);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_sys);
                    #1;
                    ready_si = ($urandom_range(0, 2) != 0);
                end
                ready_si = 1'b1;
            end
        join
        drain();

        // Four back-to-back inputs, downstream stalled for cycles 2-4
        saw_rdy_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(vecs[i + 4]);
            end
            begin
                ready_si = 1'b1;
                @(posedge clk_sys);
                #1;
                ready_si = 1'b0;
                repeat (3) begin
                    @(posedge clk_sys);
                    #1;
                end
                ready_si = 1'b1;
            end
        join
        drain();
        check_val("bp_ready_drop", saw_rdy_low, 1);

        // Latency with no stall
        latency(vecs[0]);

        // Reset with two operations in flight
        ready_si = 1'b1;
        drive(vecs[12]);
        @(posedge clk_sys);
        #1;
        drive(vecs[13]);
        @(posedge clk_sys);
        #1;
        valid_si = 1'b0;
        check_val("pre_rst_valid", valid_so, 1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check_val("rst_async_valid", valid_so, 0);
        check_val("rst_async_result", result_do, 0);
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_sys);
            #1;
            check_val("rst_no_stale", valid_so, 0);
        end
        latency(vecs[16]);

        // Flush with one operation in flight and one presented
        drive(vecs[20]);
        @(posedge clk_sys);
        #1;
        drive(vecs[21]);
        flush_si = 1'b1;
        @(posedge clk_sys);
        #1;
        flush_si = 1'b0;
        valid_si = 1'b0;
        check_val("flush_ready", ready_so, 1);
        for (int i = 0; i < 3; i++) begin
            check_val("flush_no_out", valid_so, 0);
            @(posedge clk_sys);
            #1;
        end
        latency(vecs[27]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpu_ftoi_pipe.md
FPU_FTOI_PIPE -- requirements
Module: fpu_ftoi_pipe

Interface
REQ-001 Parameter C_EXP, default 8: operand exponent width.
REQ-002 Parameter C_MANT, default 23: operand fraction width, hidden bit excluded.
REQ-003 Parameter C_BIAS, default 127: exponent bias.
REQ-004 Parameter C_INT, default 32: result integer width; legal range 8..64.
REQ-005 Clk_CI  in  1: sole clock, rising edge.
REQ-006 Rst_RBI  in  1: reset, asynchronous, active-low.
REQ-007 Flush_SI  in  1: synchronous pipeline clear.
REQ-008 Valid_SI  in  1: input operation valid.
REQ-009 Ready_SO  out  1: block accepts input this cycle.
REQ-010 Operand_a_DI  in  C_EXP+C_MANT+1: packed IEEE-754 operand, sign at MSB.
REQ-011 Signed_SI  in  1: 1 = signed result, 0 = unsigned result.
REQ-012 RM_SI  in  3: rounding mode, 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes behave as RNE.
REQ-013 Valid_SO  out  1: result valid.
REQ-014 Ready_SI  in  1: downstream accepts result.
REQ-015 Result_DO  out  C_INT: integer result.
REQ-016 OF_SO, IV_SO, IX_SO, Zero_SO  out  1 each: overflow, invalid, inexact, zero flags, qualified by Valid_SO.

Function
REQ-017 Two register stages: S1 unpacks, classifies and aligns the mantissa; S2 rounds, saturates, negates and sets flags; latency exactly 2 cycles with no stall.
REQ-018 Ready_SO = ~S1_valid | ~S2_valid | Ready_SI; a transfer occurs on Valid_SI & Ready_SO.
REQ-019 S2 loads from S1 when ~S2_valid | Ready_SI; a stage never drops or duplicates an operation, and order is preserved.
REQ-020 Valid_SO, Result_DO and the flags stay stable while Valid_SO & ~Ready_SI.
REQ-021 Exponent 0 is a subnormal or zero input; it uses the unbiased exponent 1-C_BIAS with hidden bit 0.
REQ-022 Alignment keeps the integer magnitude plus guard and sticky bits; shifts at or beyond C_INT+1 set the overflow candidate.
REQ-023 Rounding uses guard, sticky, LSB, sign and RM_SI per IEEE-754; a carry out of rounding is rechecked against range.
REQ-024 Signed range is -2^(C_INT-1) to 2^(C_INT-1)-1; -2^(C_INT-1) is exact and raises no flag.
REQ-025 Unsigned range is 0 to 2^C_INT-1; a negative input whose rounded value is -0 returns 0 with IX only.
REQ-026 Out of range gives OF=1 and IV=1, with a saturated result: signed max/min by sign; unsigned all-ones for positive, 0 for negative.
REQ-027 NaN (any sign) gives IV=1, OF=0, and returns signed max or unsigned all-ones.
REQ-028 Infinity saturates per REQ-026.
REQ-029 IX = discarded bits nonzero & ~IV.
REQ-030 Zero_SO = (Result_DO == 0) & ~IV.
REQ-031 Flush_SI clears S1_valid and S2_valid at the next edge; an input presented in the same cycle is discarded; Ready_SO is 1 the cycle after a flush.

Reset
REQ-032 Rst_RBI low asynchronously clears S1_valid, S2_valid and all data and flag registers to 0.
REQ-033 During reset, Valid_SO = 0 and Result_DO = 0, all flags are 0, and Ready_SO = 1 once reset is released.
REQ-034 Operations in flight at reset assertion are lost; no output appears for them after release.

Structure
REQ-035 fpu_defs gains the rounding-mode enum type and the C_INT default; classification encoding (zero/sub/norm/inf/nan) is also defined there.
REQ-036 One sub-module fpu_ftoi_round implements combinational rounding (guard/sticky/LSB/mode to increment) and is instantiated in S2.
REQ-037 No latches, a single clock domain, and no multi-cycle paths.

Verification
REQ-038 Test: 0x3FC00000 (1.5), signed. RNE -> 2, IX=1; RTZ -> 1, IX=1; RDN -> 1; RUP -> 2.
REQ-039 Test: 0x4F000000 (2^31). Signed -> 0x7FFFFFFF, OF=1, IV=1; unsigned -> 0x80000000, no flags; 0xCF000000 signed -> 0x80000000, no flags.
REQ-040 Test: 0x7FC00000 NaN. Signed -> 0x7FFFFFFF, IV=1; 0xFF800000 (-inf) unsigned -> 0, IV=1, OF=1.
REQ-041 Test: 0xBE800000 (-0.25), unsigned. RTZ -> 0, IX=1, IV=0; RDN -> 0, IV=1.
REQ-042 Test: 4 back-to-back inputs, with Ready_SI low for cycles 2-4. Ready_SO drops when both stages are full; all 4 results appear in order, with values unchanged while stalled.
REQ-043 Test: Rst_RBI pulsed low with 2 operations in flight. Valid_SO drops immediately; no stale result appears after release; the next input returns after 2 cycles.
